// File: rtl/layer_compositor.sv
// Layer compositor: two-stage pipeline merging LAYERS 1-bit-per-channel layers
// into one VGA pixel, with syncs delayed to match and per-frame collision capture.
module layer_compositor #(
    parameter int unsigned         LAYERS = 8,
    parameter int unsigned         RGB_W  = 3,
    parameter logic [RGB_W-1:0]    BG_RGB = '0,
    localparam int unsigned        LW     = $clog2(LAYERS)
) (
    input  logic                      clk25,
    input  logic                      reset_n,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      video_on_in,
    input  logic [LAYERS-1:0]         layer_valid,
    input  logic [RGB_W*LAYERS-1:0]   layer_rgb_flat,
    input  logic [LAYERS-1:0]         layer_en,
    input  logic                      prio_hi_first,
    output logic [3:0]                vga_r,
    output logic [3:0]                vga_g,
    output logic [3:0]                vga_b,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      video_on_out,
    output logic                      top_valid,
    output logic [LW-1:0]             top_layer,
    output logic [LAYERS-1:0]         collide_mask,
    output logic                      frame_done
);

    logic [LAYERS-1:0]       eff_valid_d, eff_valid_q;
    logic [RGB_W*LAYERS-1:0] rgb_s1_d, rgb_s1_q;
    logic                    prio_s1_d, prio_s1_q;
    logic                    hs_s1_d, hs_s1_q;
    logic                    vs_s1_d, vs_s1_q;
    logic                    von_s1_d, von_s1_q;

    logic [2:0]              pix_d, pix_q;
    logic                    hs_s2_d, hs_s2_q;
    logic                    vs_s2_d, vs_s2_q;
    logic                    von_s2_d, von_s2_q;
    logic                    top_valid_d, top_valid_q;
    logic [LW-1:0]           top_layer_d, top_layer_q;

    logic [LAYERS-1:0]       acc_d, acc_q;
    logic [LAYERS-1:0]       collide_mask_d, collide_mask_q;
    logic                    frame_done_d, frame_done_q;

    logic                    win_found;
    logic [LW-1:0]           win_idx;
    logic [RGB_W-1:0]        win_rgb;
    logic [LAYERS-1:0]       contrib;
    logic                    frame_edge;

    always_comb begin
        eff_valid_d = layer_valid & layer_en & {LAYERS{video_on_in}};
        rgb_s1_d    = layer_rgb_flat;
        prio_s1_d   = prio_hi_first;
        hs_s1_d     = hsync_in;
        vs_s1_d     = vsync_in;
        von_s1_d    = video_on_in;
    end

    // Scan in priority order; the first enabled hit is the winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < LAYERS; i++) begin
            if (!win_found && eff_valid_q[prio_s1_q ? (LAYERS - 1 - i) : i]) begin
                win_found = 1'b1;
                win_idx   = prio_s1_q ? LW'(LAYERS - 1 - i) : LW'(i);
            end
        end
    end

    always_comb begin
        win_rgb     = win_found ? rgb_s1_q[win_idx*RGB_W +: RGB_W] : BG_RGB;
        pix_d       = von_s1_q ? {win_rgb[RGB_W-1], win_rgb[RGB_W-2], win_rgb[RGB_W-3]} : 3'b000;
        top_valid_d = win_found;
        top_layer_d = win_idx;
        hs_s2_d     = hs_s1_q;
        vs_s2_d     = vs_s1_q;
        von_s2_d    = von_s1_q;
    end

    // x & (x-1) is nonzero exactly when two or more bits are set.
    always_comb begin
        contrib    = ((eff_valid_q & (eff_valid_q - LAYERS'(1))) != '0) ? eff_valid_q : '0;
        frame_edge = vs_s2_q & ~vs_s1_q;
        if (frame_edge) begin
            collide_mask_d = acc_q | contrib;
            acc_d          = '0;
            frame_done_d   = 1'b1;
        end else begin
            collide_mask_d = collide_mask_q;
            acc_d          = acc_q | contrib;
            frame_done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            eff_valid_q    <= '0;
            rgb_s1_q       <= '0;
            prio_s1_q      <= 1'b0;
            hs_s1_q        <= 1'b1;
            vs_s1_q        <= 1'b1;
            von_s1_q       <= 1'b0;
            pix_q          <= '0;
            hs_s2_q        <= 1'b1;
            vs_s2_q        <= 1'b1;
            von_s2_q       <= 1'b0;
            top_valid_q    <= 1'b0;
            top_layer_q    <= '0;
            acc_q          <= '0;
            collide_mask_q <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            eff_valid_q    <= eff_valid_d;
            rgb_s1_q       <= rgb_s1_d;
            prio_s1_q      <= prio_s1_d;
            hs_s1_q        <= hs_s1_d;
            vs_s1_q        <= vs_s1_d;
            von_s1_q       <= von_s1_d;
            pix_q          <= pix_d;
            hs_s2_q        <= hs_s2_d;
            vs_s2_q        <= vs_s2_d;
            von_s2_q       <= von_s2_d;
            top_valid_q    <= top_valid_d;
            top_layer_q    <= top_layer_d;
            acc_q          <= acc_d;
            collide_mask_q <= collide_mask_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign vga_r        = {4{pix_q[2]}};
    assign vga_g        = {4{pix_q[1]}};
    assign vga_b        = {4{pix_q[0]}};
    assign hsync_out    = hs_s2_q;
    assign vsync_out    = vs_s2_q;
    assign video_on_out = von_s2_q;
    assign top_valid    = top_valid_q;
    assign top_layer    = top_layer_q;
    assign collide_mask = collide_mask_q;
    assign frame_done   = frame_done_q;

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised pixel compositor for the 640x480 VGA game pipeline, merging LAYERS sprite/bullet/enemy layers into one 4-bit-per-channel VGA pixel. It adds the following on top of the fixed user/bullet/mosquito/fly priority chain:
- per-layer enables
- a runtime-selectable priority direction
- a 2-stage registered pipeline, with hsync/vsync/video_on delayed to match
- per-frame collision detection latched at each frame boundary, for scoring and the buzzer

It sits between the sprite drawers and the VGA pins.

## Interface
Parameters:
- LAYERS, 8, number of input layers; legal range 2..32
- RGB_W, 3, bits per input colour (1 bit each R,G,B)
- BG_RGB, 3'b000, colour when no enabled layer is valid
- LW, $clog2(LAYERS), width of top_layer (derived, not overridable)

Ports:
- clk25  in  1  pixel clock, 25 MHz
- reset_n  in  1  synchronous, active-low reset
- hsync_in  in  1  raw hsync from vga_controller (active low)
- vsync_in  in  1  raw vsync from vga_controller (active low)
- video_on_in  in  1  visible-area flag
- layer_valid  in  LAYERS  bit i = layer i has an opaque pixel at the current x,y
- layer_rgb_flat  in  RGB_W*LAYERS  layer i colour at [i*RGB_W +: RGB_W]
- layer_en  in  LAYERS  per-layer enable; a disabled layer is ignored for drawing and for collisions
- prio_hi_first  in  1  0: lowest index wins; 1: highest index wins
- vga_r, vga_g, vga_b  out  4 each  each output colour bit replicated 4x; forced 0 when video_on_out=0
- hsync_out, vsync_out, video_on_out  out  1 each  inputs delayed 2 cycles
- top_valid  out  1  an enabled layer won at this pixel
- top_layer  out  LW  index of the winning layer; 0 when top_valid=0
- collide_mask  out  LAYERS  bit i = layer i overlapped another enabled layer during the last complete frame
- frame_done  out  1  1-cycle pulse when collide_mask updates

## Operation
- Stage 1 (registered):
  - eff_valid = layer_valid & layer_en & {LAYERS{video_on_in}}
  - capture eff_valid, layer_rgb_flat, prio_hi_first, and the 3 sync/video inputs
- Stage 2 (registered):
  - Winner selection:
    - prio_hi_first=0: the lowest set bit of stage-1 eff_valid wins
    - prio_hi_first=1: the highest set bit wins
  - Drive rgb = winner colour, else BG_RGB; set top_valid and top_layer
- prio_hi_first is sampled in stage 1, so a mid-line change affects whole pixels only, never a split pixel.
- Collision accumulator (acc, LAYERS bits) is updated from stage-1 eff_valid:
  - when popcount ≥ 2: acc |= eff_valid
  - a single valid layer never sets its bit
- Frame boundary is the falling edge of stage-1 vsync (1→0, detected against the prior registered value). On that cycle:
  - collide_mask <= acc | current contribution
  - acc <= 0
  - frame_done <= 1 for exactly one cycle
- Collisions on the edge cycle itself belong to the frame being closed. video_on is low during vsync, so in normal operation this contribution is zero.
- No edge (vsync stuck): acc keeps accumulating; collide_mask holds.
- Reset (reset_n=0 at a clk25 edge) takes effect on that edge, including mid-frame. Reset values:
  - vga_r/g/b = 0
  - hsync_out = vsync_out = 1
  - video_on_out = 0
  - top_valid = 0, top_layer = 0
  - collide_mask = 0, frame_done = 0
  - acc = 0
  - pipeline registers 0, except sync registers = 1
- First frame after reset: no frame_done until the first vsync falling edge seen after release.

## Timing
- Latency is 2 clk25 cycles from inputs to vga_*, top_*, hsync_out, vsync_out and video_on_out; all are aligned with each other.
- One pixel per cycle; no stalls, no back-pressure.
- collide_mask and frame_done change on the cycle after stage 1 sees the vsync fall, i.e. 2 cycles after vsync_in falls; frame_done is aligned with vsync_out falling.
- Critical path: a LAYERS-wide priority encode plus mux in stage 2. For LAYERS=32 this must close at 25 MHz.

## Test plan
- Pipeline: video_on_in=1, only layer 3 valid with rgb 3'b101, all enabled → 2 cycles later vga_r=4'hF, vga_g=0, vga_b=4'hF, top_layer=3, top_valid=1. hsync_in pulse reappears on hsync_out exactly 2 cycles later.
- Priority: layers 1 (3'b100) and 6 (3'b001) both valid.
  - prio_hi_first=0 → red, top_layer=1
  - toggle to 1 → blue, top_layer=6 on the pixel 2 cycles after the toggle
  - layer_en[6]=0 → red again
- Blanking: video_on_in=0 with layers valid → vga_*=0, top_valid=0, and acc unchanged.
- Collision: in frame N, layers 0 and 2 overlap for one pixel and layer 5 is alone. At the vsync fall → collide_mask=8'b0000_0101 and frame_done high for 1 cycle. Frame N+1 with no overlap → collide_mask=0 at the next edge.
- Reset mid-frame: assert reset_n=0 for 1 cycle during an active line with collisions pending → the next cycle shows all outputs at their reset values, including hsync_out=vsync_out=1. The next frame_done reports only overlaps after release.
